// File: rtl/sum4_accumulator.sv
// rtl/sum4_accumulator.sv - saturating multi-beat accumulator for 5-bit adder results
//
// Collects N_SAMPLES beats of {carry, sum} over a valid/ready handshake into a
// saturating ACC_W-bit total, then offers the result on an output handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begins a run (honoured only in IDLE)
//   in_valid   in   upstream beat valid
//   in_ready   out  high while accumulating
//   in_sum     in   adder sum bits [3:0]
//   in_carry   in   adder carry-out
//   out_valid  out  result valid (DONE)
//   out_ready  in   downstream accepts the result
//   out_total  out  accumulated, saturated total
//   out_count  out  beats accepted in the current or last run
//   out_ovf    out  total saturated at some point in the run
//   out_match  out  final total equals TARGET (only while out_valid)
//   busy       out  not IDLE
module sum4_accumulator #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned TARGET    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_match,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       count_q;
  logic             ovf_q;
  logic             match_q;

  logic             beat;
  logic             last_beat;
  logic             out_hs;
  logic [ACC_W:0]   operand;
  logic [ACC_W:0]   acc_sum;
  logic             sat;
  logic [ACC_W-1:0] acc_next;
  logic             next_match;

  // Handshake qualifiers come from the registered state only, so no input
  // reaches an output combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (count_q == LAST_COUNT);
  assign out_hs    = out_valid & out_ready;

  // One spare bit above the accumulator catches the carry out of the add;
  // with ACC_W >= 5 a single add of at most 31 can never wrap past it.
  assign operand  = {{(ACC_W - 4){1'b0}}, in_carry, in_sum};
  assign acc_sum  = {1'b0, acc_q} + operand;
  assign sat      = acc_sum[ACC_W];
  assign acc_next = sat ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

  // Compare in 32 bits so an out-of-range TARGET never matches by truncation.
  assign next_match = ({{(32 - ACC_W){1'b0}}, acc_next} == 32'(TARGET));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DONE;
      DONE:    if (out_hs)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q   <= acc_next;
            count_q <= count_q + 8'd1;
            ovf_q   <= ovf_q | sat;
            // Registered on the way into DONE so it reflects the final total.
            if (last_beat) begin
              match_q <= next_match;
            end
          end
        end
        DONE: begin
          // Total, count and ovf stay visible in IDLE; match is DONE-only.
          if (out_hs) begin
            match_q <= 1'b0;
          end
        end
        default: begin
          match_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_total = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;
  assign out_match = match_q;

endmodule

// File: tb/tb_sum4_accumulator.sv
// tb/tb_sum4_accumulator.sv - scoreboard bench for sum4_accumulator
module tb_sum4_accumulator;

  localparam int N    = 4;
  localparam int W    = 6;
  localparam int TGT  = 62;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_sum = 4'd0;
  logic         in_carry = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_total;
  logic [7:0]   out_count;
  logic         out_ovf;
  logic         out_match;
  logic         busy;

  sum4_accumulator #(
    .N_SAMPLES (N),
    .ACC_W     (W),
    .TARGET    (TGT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_match (out_match),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int total;
    int count;
    int ovf;
    int match;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v[N]);
    exp_t e;
    int   a;
    a     = 0;
    e.ovf = 0;
    for (int i = 0; i < N; i++) begin
      a = a + v[i];
      if (a > MAXV) begin
        a     = MAXV;
        e.ovf = 1;
      end
    end
    e.total = a;
    e.count = N;
    e.match = (a == TGT) ? 1 : 0;
    return e;
  endfunction

  // Pops one expectation per output handshake (sampled on the falling edge).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_total", 32'(out_total), e.total);
        chk("sb_count", 32'(out_count), e.count);
        chk("sb_ovf",   32'(out_ovf),   e.ovf);
        chk("sb_match", 32'(out_match), e.match);
      end
    end
  end

  task automatic run(input int v[N], input bit gaps, input int hold, input bit poke);
    exp_t e;
    e = model(v);
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_start", 32'(in_ready), 1);
    chk("busy_accum", 32'(busy), 1);
    chk("valid_in_accum", 32'(out_valid), 0);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          chk("stall_count", 32'(out_count), i);
          chk("stall_ready", 32'(in_ready), 1);
        end
      end
      in_valid = 1'b1;
      {in_carry, in_sum} = 5'(v[i]);
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < N - 1) chk("count_per_beat", 32'(out_count), i + 1);
    end
    chk("valid_after_last", 32'(out_valid), 1);
    chk("ready_in_done", 32'(in_ready), 0);
    chk("done_total", 32'(out_total), e.total);
    chk("done_count", 32'(out_count), e.count);
    chk("done_ovf", 32'(out_ovf), e.ovf);
    chk("done_match", 32'(out_match), e.match);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start    = 1'b1;
        in_valid = 1'b1;
        in_sum   = 4'hf;
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_total", 32'(out_total), e.total);
      chk("hold_count", 32'(out_count), N);
      chk("hold_match", 32'(out_match), e.match);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_hs", 32'(busy), 0);
    chk("valid_in_idle", 32'(out_valid), 0);
    chk("match_in_idle", 32'(out_match), 0);
    chk("total_kept", 32'(out_total), e.total);
    chk("count_kept", 32'(out_count), N);
    chk("ovf_kept", 32'(out_ovf), e.ovf);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_total", 32'(out_total), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    chk("rst_match", 32'(out_match), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run('{3, 3, 3, 3}, 1'b0, 0, 1'b0);       // 12, no match
    run('{31, 31, 0, 0}, 1'b0, 0, 1'b0);     // 62 == TARGET
    run('{31, 31, 1, 0}, 1'b0, 0, 1'b0);     // exactly 63, no ovf
    run('{31, 31, 2, 0}, 1'b0, 0, 1'b0);     // 64 saturates, ovf sticky through +0
    run('{31, 31, 31, 31}, 1'b1, 10, 1'b1);  // gaps, held result, ignored controls
    run('{5, 16, 7, 20}, 1'b1, 2, 1'b0);     // 48

    in_valid = 1'b1;
    in_sum   = 4'd9;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_in_valid_busy", 32'(busy), 0);
      chk("idle_in_valid_ready", 32'(in_ready), 0);
      chk("idle_in_valid_count", 32'(out_count), N);
      chk("idle_in_valid_total", 32'(out_total), 48);
    end
    in_valid = 1'b0;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      {in_carry, in_sum} = 5'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("pre_reset_count", 32'(out_count), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_total", 32'(out_total), 0);
    chk("mid_rst_count", 32'(out_count), 0);
    chk("mid_rst_ovf", 32'(out_ovf), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run('{1, 1, 1, 1}, 1'b0, 0, 1'b0);       // 4 after abort

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sum4_accumulator.md
# sum4_accumulator

Downstream consumer of the 4-bit adder stage. It accepts a stream of 5-bit adder results (4-bit sum plus carry-out) over a valid/ready handshake and accumulates exactly N_SAMPLES of them into a saturating running total. It then presents the total, an overflow flag and a target-equality flag on an output handshake. It converts the combinational adder into a sequential multi-operand summing stage.

## Interface
- N_SAMPLES, 4: beats accumulated per run; legal range 1..255.
- ACC_W, 8: accumulator width; legal range 5..16.
- TARGET, 0: constant compared against the final total for out_match.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run; sampled only in IDLE.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage accepts beats.
- in_sum  in  4  adder sum bits.
- in_carry  in  1  adder carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_total  out  ACC_W  accumulated total.
- out_count  out  8  beats accepted in the current or last run.
- out_ovf  out  1  the total saturated during the run.
- out_match  out  1  out_total == TARGET; meaningful only while out_valid.
- busy  out  1  state is not IDLE.

## Operation
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). While reset is asserted:
  - state goes to IDLE;
  - out_total, out_count, out_ovf, out_match, out_valid, in_ready and busy are all 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - When start = 1: clear the accumulator, count and ovf, then go to ACCUM.
- ACCUM:
  - in_ready = 1.
  - Each beat with in_valid & in_ready is accepted.
  - The operand is {in_carry, in_sum}, zero-extended to ACC_W+1 bits (value 0..31).
  - acc_next = acc + operand. If acc_next > 2^ACC_W − 1, acc saturates to all-ones and ovf is set; ovf is sticky for the run.
  - Count increments per accepted beat. When the count reaches N_SAMPLES, go to DONE.
- DONE:
  - out_valid = 1; in_ready = 0.
  - out_total, out_count, out_ovf and out_match are held stable.
  - When out_valid & out_ready, go to IDLE.
  - out_total, out_count and out_ovf keep their values in IDLE until the next start.
- start is ignored in ACCUM and DONE.
- in_valid outside ACCUM is ignored; no beat is consumed.
- out_match is registered and computed from the final total on DONE entry. It is 0 outside DONE.

## Timing
- in_ready and out_valid are decoded from the registered state only. There is no combinational path from any input to any output.
- Start sampled in IDLE at edge t: in_ready = 1 from cycle t+1.
- Last beat accepted at edge t: out_valid = 1 and the final values are visible in cycle t+1. in_ready = 0 in that same cycle.
- Minimum run length is N_SAMPLES + 2 cycles: start, N beats, one result cycle (with out_ready = 1).
- Gaps in in_valid stall accumulation without penalty. The state is unchanged and the count is not advanced.
- out_ready low in DONE holds all outputs indefinitely.
- Output handshake at edge t: IDLE from t+1. A start asserted in the cycle after t is accepted at t+1.
- rst_n asserted mid-run, in any state: immediate return to IDLE with all outputs 0. The partial sum is discarded. No output handshake occurs.
- Saturation boundary: acc_next exactly 2^ACC_W − 1 does not set ovf. 2^ACC_W sets it.

## Test plan
- Basic run: defaults, start, four beats of {0,0011} -> out_valid one cycle after the 4th beat; out_total = 12, out_count = 4, out_ovf = 0, out_match = 0.
- Carry and match: TARGET = 62, N_SAMPLES = 2, beats {1,1111} and {1,1111} -> out_total = 62, out_match = 1.
- Saturation: N_SAMPLES = 16, ACC_W = 8, sixteen beats of value 31 -> out_total = 255, out_ovf = 1. A separate run with total exactly 255 -> out_ovf = 0.
- Handshake stress: random in_valid gaps and out_ready held low for 10 cycles -> outputs stable, in_ready = 0 throughout DONE, exactly N beats consumed, IDLE one cycle after out_ready rises.
- Ignored controls: start pulsed in ACCUM and DONE, and in_valid driven in IDLE -> no change to count or total; busy stays correct.
- Reset mid-run: rst_n low after 2 of 4 beats -> all outputs 0 immediately. A new start with four beats of 1 -> out_total = 4.
